reversalmb_module_initiator: RTL and testbench

Initiator side of the MBINIT.REVERSALMB handshake in the LTSM MBINIT sequence, paired with the partner-side responder over the sideband. After REPAIRVAL completes, it sends init/clear_error/result/done requests and drives the local per-lane-ID pattern generator. It evaluates the partner's 16-bit per-lane result and applies lane reversal at most once. It then signals completion, or an error if reversal does not fix the lanes.

---
 rtl/reversalmb_module_initiator.sv | 134 +++++++++++++
 tb/tb_reversalmb_module_initiator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reversalmb_module_initiator.sv
// rtl/reversalmb_module_initiator.sv - MBINIT.REVERSALMB initiator: sideband handshake, lane-ID pattern and one-shot lane reversal
module reversalmb_module_initiator #(
  parameter int PASS_MIN = 9
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        i_REPAIRVAL_end,
  input  logic [3:0]  i_Rx_SbMessage,
  input  logic        i_msg_valid,
  input  logic        i_Busy_SideBand,
  input  logic        i_falling_edge_busy,
  input  logic [15:0] i_REVERSAL_Pattern_Result_logged,
  input  logic        i_pattern_done,
  output logic [3:0]  o_TX_SbMessage,
  output logic        o_ValidOutDatat_Module,
  output logic        o_LaneID_Pattern_En,
  output logic        o_Clear_Pattern_Comparator,
  output logic        o_Lane_Reversal_En,
  output logic        o_MBINIT_REVERSALMB_Module_end,
  output logic        o_MBINIT_REVERSALMB_Error
);

  localparam logic [3:0] INIT_REQ_MSG   = 4'b0001;
  localparam logic [3:0] INIT_RESP_MSG  = 4'b0010;
  localparam logic [3:0] CLEAR_REQ_MSG  = 4'b0011;
  localparam logic [3:0] CLEAR_RESP_MSG = 4'b0100;
  localparam logic [3:0] RESULT_REQ_MSG = 4'b0101;
  localparam logic [3:0] RESULT_RESP_MSG= 4'b0110;
  localparam logic [3:0] DONE_REQ_MSG   = 4'b0111;
  localparam logic [3:0] DONE_RESP_MSG  = 4'b1000;

  typedef enum logic [4:0] {
    IDLE, CHK_BUSY_INIT, INIT_REQ, WAIT_INIT_RESP,
    CHK_BUSY_CLEAR, CLEAR_REQ, WAIT_CLEAR_RESP, PATTERN,
    CHK_BUSY_RESULT, RESULT_REQ, WAIT_RESULT_RESP, EVAL,
    CHK_BUSY_DONE, DONE_REQ, WAIT_DONE_RESP, DONE, ERROR
  } state_t;

  state_t      state, next;
  logic [15:0] result;
  logic [4:0]  ones;
  logic        set_rev;
  logic [3:0]  tx_code;
  logic        tx_valid;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 16; i++) ones = ones + 5'(result[i]);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next    = state;
    set_rev = 1'b0;
    case (state)
      IDLE:             if (i_REPAIRVAL_end) next = CHK_BUSY_INIT;
      CHK_BUSY_INIT:    if (!i_Busy_SideBand) next = INIT_REQ;
      INIT_REQ:         if (i_falling_edge_busy) next = WAIT_INIT_RESP;
      WAIT_INIT_RESP:   if (i_msg_valid && i_Rx_SbMessage == INIT_RESP_MSG) next = CHK_BUSY_CLEAR;
      CHK_BUSY_CLEAR:   if (!i_Busy_SideBand) next = CLEAR_REQ;
      CLEAR_REQ:        if (i_falling_edge_busy) next = WAIT_CLEAR_RESP;
      WAIT_CLEAR_RESP:  if (i_msg_valid && i_Rx_SbMessage == CLEAR_RESP_MSG) next = PATTERN;
      PATTERN:          if (i_pattern_done) next = CHK_BUSY_RESULT;
      CHK_BUSY_RESULT:  if (!i_Busy_SideBand) next = RESULT_REQ;
      RESULT_REQ:       if (i_falling_edge_busy) next = WAIT_RESULT_RESP;
      WAIT_RESULT_RESP: if (i_msg_valid && i_Rx_SbMessage == RESULT_RESP_MSG) next = EVAL;
      EVAL: begin
        if (ones >= 5'(PASS_MIN)) begin
          next = CHK_BUSY_DONE;
        end else if (!o_Lane_Reversal_En) begin
          // one retry with the TX lane mapping reversed
          next    = CHK_BUSY_CLEAR;
          set_rev = 1'b1;
        end else begin
          next = ERROR;
        end
      end
      CHK_BUSY_DONE:    if (!i_Busy_SideBand) next = DONE_REQ;
      DONE_REQ:         if (i_falling_edge_busy) next = WAIT_DONE_RESP;
      WAIT_DONE_RESP:   if (i_msg_valid && i_Rx_SbMessage == DONE_RESP_MSG) next = DONE;
      DONE:             next = DONE;
      ERROR:            next = ERROR;
      default:          next = IDLE;
    endcase
    if (!i_REPAIRVAL_end) begin
      next    = IDLE;
      set_rev = 1'b0;
    end
  end

  always_comb begin
    tx_valid = 1'b1;
    case (next)
      INIT_REQ:   tx_code = INIT_REQ_MSG;
      CLEAR_REQ:  tx_code = CLEAR_REQ_MSG;
      RESULT_REQ: tx_code = RESULT_REQ_MSG;
      DONE_REQ:   tx_code = DONE_REQ_MSG;
      default: begin
        tx_code  = 4'b0000;
        tx_valid = 1'b0;
      end
    endcase
  end

  // outputs are decoded from next so they line up with the state being entered
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      o_TX_SbMessage                 <= 4'b0000;
      o_ValidOutDatat_Module         <= 1'b0;
      o_LaneID_Pattern_En            <= 1'b0;
      o_Clear_Pattern_Comparator     <= 1'b0;
      o_Lane_Reversal_En             <= 1'b0;
      o_MBINIT_REVERSALMB_Module_end <= 1'b0;
      o_MBINIT_REVERSALMB_Error      <= 1'b0;
      result                         <= '0;
    end else begin
      o_TX_SbMessage                 <= tx_code;
      o_ValidOutDatat_Module         <= tx_valid;
      o_LaneID_Pattern_En            <= (next == PATTERN);
      o_Clear_Pattern_Comparator     <= (next == PATTERN) && (state != PATTERN);
      o_MBINIT_REVERSALMB_Module_end <= (next == DONE);
      o_MBINIT_REVERSALMB_Error      <= (next == ERROR);
      if (next == IDLE)  o_Lane_Reversal_En <= 1'b0;
      else if (set_rev)  o_Lane_Reversal_En <= 1'b1;
      if (state == WAIT_RESULT_RESP && next == EVAL)
        result <= i_REVERSAL_Pattern_Result_logged;
    end
  end

endmodule

// File: tb/tb_reversalmb_module_initiator.sv
// tb/tb_reversalmb_module_initiator.sv - randomized partner model with scoreboard for the REVERSALMB initiator
module tb_reversalmb_module_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  rx = 4'd0;
  logic        mv = 1'b0;
  logic        busy = 1'b0;
  logic        feb = 1'b0;
  logic [15:0] data = 16'd0;
  logic        pdone = 1'b0;
  logic [3:0]  o_tx;
  logic        o_valid, o_pat, o_clr, o_rev, o_end, o_err;

  reversalmb_module_initiator #(.PASS_MIN(9)) dut (
    .CLK(clk),
    .rst(rst),
    .i_REPAIRVAL_end(en),
    .i_Rx_SbMessage(rx),
    .i_msg_valid(mv),
    .i_Busy_SideBand(busy),
    .i_falling_edge_busy(feb),
    .i_REVERSAL_Pattern_Result_logged(data),
    .i_pattern_done(pdone),
    .o_TX_SbMessage(o_tx),
    .o_ValidOutDatat_Module(o_valid),
    .o_LaneID_Pattern_En(o_pat),
    .o_Clear_Pattern_Comparator(o_clr),
    .o_Lane_Reversal_En(o_rev),
    .o_MBINIT_REVERSALMB_Module_end(o_end),
    .o_MBINIT_REVERSALMB_Error(o_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] msg;
    logic       rev;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic exp_end, exp_rev;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: every new request on the sideband must match the next expected one
  always @(negedge clk) begin
    if (!rst && o_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tx: got msg %0h with no request expected", o_tx);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_msg", 32'(o_tx), 32'(mon_e.msg));
        check("tx_rev", 32'(o_rev), 32'(mon_e.rev));
      end
    end
    prev_valid = o_valid;
  end

  function automatic void push(input logic [3:0] m, input logic r);
    exp_t e;
    e.msg = m;
    e.rev = r;
    exp_q.push_back(e);
  endfunction

  // reference: pass needs at least 9 of 16 lanes, a single reversed retry is allowed
  function automatic void model(input logic [15:0] r0, input logic [15:0] r1);
    push(4'd1, 1'b0);
    push(4'd3, 1'b0);
    push(4'd5, 1'b0);
    if ($countones(r0) >= 9) begin
      push(4'd7, 1'b0);
      exp_end = 1'b1;
      exp_rev = 1'b0;
    end else begin
      push(4'd3, 1'b1);
      push(4'd5, 1'b1);
      exp_rev = 1'b1;
      if ($countones(r1) >= 9) begin
        push(4'd7, 1'b1);
        exp_end = 1'b1;
      end else begin
        exp_end = 1'b0;
      end
    end
  endfunction

  function automatic logic [15:0] with_ones(input int k);
    logic [15:0] v = 16'd0;
    while ($countones(v) < k) v[$urandom_range(0, 15)] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (which == 0 && (o_valid || o_end || o_err)) begin ok = 1'b1; break; end
      if (which == 1 && o_pat) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout: waited 300 cycles for event %0d", which);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {25'd0, o_tx, o_valid, o_pat, o_clr, o_rev, o_end, o_err} , 32'd0);
  endtask

  task automatic run_case(input logic [15:0] r0, input logic [15:0] r1, input bit do_abort,
                          input bit force_wrong, input int pre_busy);
    logic [15:0] res[2];
    int          ridx = 0;
    int          npat = 0;
    bit          ok;
    logic [3:0]  m;
    logic [3:0]  w;
    res[0] = r0;
    res[1] = r1;
    model(r0, r1);
    busy = (pre_busy > 0);
    en = 1'b1;
    tick();
    check("no_valid_in_chk_busy_init", 32'(o_valid), 32'd0);
    for (int i = 0; i < pre_busy; i++) begin
      tick();
      check("busy_holds_valid_low", 32'(o_valid), 32'd0);
    end
    busy = 1'b0;
    tick();
    check("init_req_latency", {27'd0, o_valid, o_tx}, {27'd0, 1'b1, 4'd1});
    forever begin
      wait_for(0, ok);
      if (!ok) return;
      if (o_end || o_err) break;
      m = o_tx;
      repeat ($urandom_range(0, 2)) tick();
      feb = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        mv = 1'b1;
        rx = m + 4'd1;
      end
      tick();
      feb = 1'b0;
      mv  = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      if (force_wrong || $urandom_range(0, 1) == 1) begin
        w = m + 4'd1;
        while (w == m + 4'd1) w = 4'($urandom_range(1, 8));
        if (m == 4'd3 && force_wrong) w = 4'd6;
        mv = 1'b1;
        rx = w;
        tick();
        mv = 1'b0;
        if (m == 4'd3) check("wrong_msg_ignored", 32'(o_pat), 32'd0);
      end
      mv = 1'b1;
      rx = m + 4'd1;
      if (m == 4'd5 && ridx < 2) begin
        data = res[ridx];
        ridx++;
      end
      tick();
      mv = 1'b0;
      data = 16'(($urandom));
      if (m == 4'd3) begin
        wait_for(1, ok);
        if (!ok) return;
        npat++;
        check("clear_pulse_entry", 32'(o_clr), 32'd1);
        if (do_abort && npat == 2) begin
          check("rev_before_abort", 32'(o_rev), 32'd1);
          en = 1'b0;
          tick();
          check_idle_outputs("abort_outputs_zero");
          exp_q.delete();
          return;
        end
        repeat ($urandom_range(1, 4)) tick();
        check("clear_pulse_once", 32'(o_clr), 32'd0);
        pdone = 1'b1;
        tick();
        pdone = 1'b0;
      end
      busy = 1'b1;
      repeat ($urandom_range(0, 3)) tick();
      busy = 1'b0;
    end
    check("module_end", 32'(o_end), 32'(exp_end));
    check("error", 32'(o_err), 32'(!exp_end));
    check("lane_reversal", 32'(o_rev), 32'(exp_rev));
    check("all_requests_seen", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    check("final_hold", {30'd0, o_end, o_err}, {30'd0, exp_end, !exp_end});
    en = 1'b0;
    tick();
    check_idle_outputs("disable_outputs_zero");
    tick();
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    repeat (3) tick();
    check_idle_outputs("reset_outputs_zero");
    rst = 1'b0;
    tick();
    check_idle_outputs("idle_outputs_zero");

    run_case(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    run_case(16'h0000, 16'hFFF0, 1'b0, 1'b0, 0);
    run_case(16'h00FF, 16'h00FF, 1'b0, 1'b0, 0);
    run_case(16'hFFFF, 16'h0000, 1'b0, 1'b0, 10);
    run_case(16'h0000, 16'hFFFF, 1'b1, 1'b0, 0);
    run_case(16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
    run_case(16'h01FF, 16'h0000, 1'b0, 1'b0, 0);
    for (int t = 0; t < 10; t++) begin
      a = with_ones($urandom_range(6, 11));
      b = with_ones($urandom_range(6, 11));
      run_case(a, b, 1'b0, 1'b0, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
